// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: reads BEATS memory words per instruction, assembles them
// and queues finished instructions in a first-word-fall-through FIFO for the controller.
module inst_fetch_unit #(
    parameter int INST_LEN     = 220,
    parameter int WORD_LEN     = 64,
    parameter int BEATS        = 4,
    parameter int MEM_ADDR_LEN = 16,
    parameter int CNT_LEN      = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MEM_ADDR_LEN-1:0] inst_base_addr,
    input  logic [CNT_LEN-1:0]      inst_count,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [MEM_ADDR_LEN-1:0] mem_rd_addr,
    input  logic [WORD_LEN-1:0]     mem_rd_data,
    output logic [INST_LEN-1:0]     instruct,
    output logic                    inst_empty,
    input  logic                    inst_req
);
    localparam int ASM_W = BEATS * WORD_LEN;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = PW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW:0]   DEPTH_V   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SPACE, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [MEM_ADDR_LEN-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, cur_addr;
    logic [CNT_LEN-1:0]      rem_q, rem_d, cur_rem;
    logic [BW-1:0]           beat_q, beat_d, cur_beat, rd_beat_q, rbeat_q;
    logic [CW-1:0]           infl_q, infl_d, cnt_q, cnt_d;
    logic                    busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, rvld_q;
    logic [ASM_W-1:0]        asm_q, asm_d, merged;
    logic [INST_LEN-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]           wptr_q, rptr_q;
    logic                    push, pop, want, iss, space_ok;

    // Returning beat lands in its slot; the last beat is pushed straight from here.
    always_comb begin
        merged = asm_q;
        for (int k = 0; k < BEATS; k++)
            if (rbeat_q == BW'(k)) merged[k*WORD_LEN +: WORD_LEN] = mem_rd_data;
    end

    assign push  = rvld_q && (rbeat_q == LAST_BEAT);
    assign pop   = inst_req && (cnt_q != '0);
    assign asm_d = !rvld_q ? asm_q : (push ? '0 : merged);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        infl_d    = infl_q;
        cnt_d     = cnt_q;
        cur_addr  = (state_q == IDLE) ? inst_base_addr : addr_q;
        cur_beat  = (state_q == IDLE) ? '0 : beat_q;
        cur_rem   = (state_q == IDLE) ? inst_count : rem_q;
        want      = (state_q == ISSUE) || (state_q == WAIT_SPACE) ||
                    (state_q == IDLE && start && inst_count != '0);
        // A new instruction reserves its FIFO slot when beat 0 issues.
        space_ok  = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_V;
        iss       = want && (cur_beat != '0 || space_ok);

        if (state_q == IDLE && start && inst_count == '0) done_d = 1'b1;

        if (want) begin
            busy_d  = 1'b1;
            addr_d  = cur_addr;
            beat_d  = cur_beat;
            rem_d   = cur_rem;
            state_d = WAIT_SPACE;
            if (iss) begin
                rd_en_d   = 1'b1;
                rd_addr_d = cur_addr;
                addr_d    = cur_addr + MEM_ADDR_LEN'(1);
                beat_d    = cur_beat + BW'(1);
                state_d   = ISSUE;
                if (cur_beat == '0) infl_d = infl_d + CW'(1);
                if (cur_beat == LAST_BEAT) begin
                    beat_d = '0;
                    rem_d  = cur_rem - CNT_LEN'(1);
                    if (cur_rem == CNT_LEN'(1)) state_d = DRAIN;
                end
            end
        end

        if (push) infl_d = infl_d - CW'(1);
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        if (state_q == DRAIN && push && infl_q == CW'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_beat_q <= '0;
            rbeat_q   <= '0;
            rvld_q    <= 1'b0;
            infl_q    <= '0;
            cnt_q     <= '0;
            asm_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_beat_q <= cur_beat;
            rbeat_q   <= rd_beat_q;
            rvld_q    <= rd_en_q;
            infl_q    <= infl_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= merged[INST_LEN-1:0];
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign inst_empty  = (cnt_q == '0);
    assign instruct    = inst_empty ? '0 : fifo_q[rptr_q];
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural instruction memory.
module tb_inst_fetch_unit;
    logic         clk = 1'b0;
    logic         rst_n, start, inst_req;
    logic [15:0]  inst_base_addr, mem_rd_addr;
    logic [15:0]  inst_count;
    logic         busy, done, mem_rd_en, inst_empty;
    logic [63:0]  mem_rd_data = '0;
    logic [219:0] instruct;
    int           n_cmp = 0, n_fail = 0;
    int           rd_cnt = 0, pop_cnt = 0;

    inst_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_base_addr(inst_base_addr),
        .inst_count(inst_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .instruct(instruct),
        .inst_empty(inst_empty), .inst_req(inst_req)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mw(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0013) return {16{4'(a - 16'h000F)}};
        return {a, 16'hC3A5 ^ a, ~a, a ^ 16'h5A5A};
    endfunction

    function automatic logic [219:0] exp_inst(input logic [15:0] a);
        logic [255:0] w;
        for (int k = 0; k < 4; k++) w[k*64 +: 64] = mw(a + 16'(k));
        return w[219:0];
    endfunction

    // Memory answers exactly one cycle after the strobe.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mw(mem_rd_addr) : 64'h0;
        if (rst_n && mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (rst_n && inst_req && !inst_empty) pop_cnt <= pop_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // start is high in "cycle 0"; returns in cycle 1
    task automatic go(input logic [15:0] base, input logic [15:0] cnt);
        start = 1'b1; inst_base_addr = base; inst_count = cnt;
        cyc();
        start = 1'b0;
    endtask

    task automatic pop_once();
        inst_req = 1'b1; cyc(); inst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; inst_req = 1'b0; inst_base_addr = '0; inst_count = '0;
        cyc(); cyc();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 16'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", mem_rd_addr); end
        n_cmp++; if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", inst_empty); end
        n_cmp++; if (instruct !== 220'h0) begin n_fail++; $display("FAIL reset_instruct: got %h want 0", instruct); end
        rst_n = 1'b1; cyc();
    endtask

    task automatic test_single();
        go(16'h0010, 16'd1);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en c%0d: got %b want 1", c, mem_rd_en); end
            n_cmp++; if (mem_rd_addr !== 16'(16'h000F + c)) begin n_fail++; $display("FAIL single_addr c%0d: got %h want %h", c, mem_rd_addr, 16'(16'h000F + c)); end
            cyc();
        end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en c5: got %b want 0", mem_rd_en); end
        n_cmp++; if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty c5: got %b want 1", inst_empty); end
        cyc();
        n_cmp++; if (inst_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty c6: got %b want 0", inst_empty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done c6: got %b want 1", done); end
        n_cmp++; if (instruct[63:0] !== 64'h1111111111111111) begin n_fail++; $display("FAIL single_lo: got %h want 1111111111111111", instruct[63:0]); end
        n_cmp++; if (instruct[219:192] !== 28'h4444444) begin n_fail++; $display("FAIL single_hi: got %h want 4444444", instruct[219:192]); end
        n_cmp++; if (instruct !== exp_inst(16'h0010)) begin n_fail++; $display("FAIL single_inst: got %h want %h", instruct, exp_inst(16'h0010)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy c6: got %b want 0", busy); end
        cyc();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done c7: got %b want 0", done); end
        pop_once();
        n_cmp++; if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %b want 1", inst_empty); end
    endtask

    task automatic test_zero_count();
        int r0;
        r0 = rd_cnt;
        go(16'h0040, 16'd0);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL zero_rd_en: got %b want 0", mem_rd_en); end
        cyc(); cyc();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_end: got %b want 0", done); end
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", rd_cnt - r0); end
    endtask

    task automatic test_wrap();
        logic [15:0] want_a [4];
        want_a[0] = 16'hFFFE; want_a[1] = 16'hFFFF; want_a[2] = 16'h0000; want_a[3] = 16'h0001;
        go(16'hFFFE, 16'd1);
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (mem_rd_addr !== want_a[c] || mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL wrap_addr c%0d: got %h/%b want %h/1", c + 1, mem_rd_addr, mem_rd_en, want_a[c]); end
            cyc();
        end
        cyc();
        n_cmp++; if (instruct !== exp_inst(16'hFFFE)) begin n_fail++; $display("FAIL wrap_inst: got %h want %h", instruct, exp_inst(16'hFFFE)); end
        pop_once();
    endtask

    task automatic test_backpressure();
        int r0, p0, occ, max_occ, n;
        r0 = rd_cnt; p0 = pop_cnt; max_occ = 0;
        go(16'h0100, 16'd6);
        for (int c = 0; c < 40; c++) begin
            occ = (rd_cnt - r0 + 3) / 4 - (pop_cnt - p0);
            if (occ > max_occ) max_occ = occ;
            cyc();
        end
        n_cmp++; if (rd_cnt - r0 !== 16) begin n_fail++; $display("FAIL bp_reads: got %0d want 16", rd_cnt - r0); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rd_en: got %b want 0", mem_rd_en); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b want 1", busy); end
        n_cmp++; if (instruct !== exp_inst(16'h0100)) begin n_fail++; $display("FAIL bp_head0: got %h want %h", instruct, exp_inst(16'h0100)); end
        pop_once();
        cyc();
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'h0110) begin n_fail++; $display("FAIL bp_resume: got %b/%h want 1/0110", mem_rd_en, mem_rd_addr); end
        for (int c = 0; c < 20; c++) begin
            occ = (rd_cnt - r0 + 3) / 4 - (pop_cnt - p0);
            if (occ > max_occ) max_occ = occ;
            cyc();
        end
        n_cmp++; if (rd_cnt - r0 !== 20) begin n_fail++; $display("FAIL bp_reads2: got %0d want 20", rd_cnt - r0); end
        for (int i = 1; i < 6; i++) begin
            n = 0;
            while (inst_empty && n < 50) begin cyc(); n++; end
            n_cmp++; if (instruct !== exp_inst(16'(16'h0100 + 4 * i))) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, instruct, exp_inst(16'(16'h0100 + 4 * i))); end
            occ = (rd_cnt - r0 + 3) / 4 - (pop_cnt - p0);
            if (occ > max_occ) max_occ = occ;
            pop_once();
        end
        n = 0;
        while (busy && n < 50) begin cyc(); n++; end
        n_cmp++; if (busy !== 1'b0 || inst_empty !== 1'b1) begin n_fail++; $display("FAIL bp_final: got busy %b empty %b want 0 1", busy, inst_empty); end
        n_cmp++; if (max_occ > 4) begin n_fail++; $display("FAIL bp_max_occ: got %0d want <=4", max_occ); end
    endtask

    task automatic test_cadence();
        int pops = 0;
        go(16'h0200, 16'd3);
        for (int c = 0; c < 40; c++) begin
            if (pops < 3 && !inst_empty && !inst_req) begin
                n_cmp++; if (instruct !== exp_inst(16'(16'h0200 + 4 * pops))) begin n_fail++; $display("FAIL cad_order%0d: got %h want %h", pops, instruct, exp_inst(16'(16'h0200 + 4 * pops))); end
                inst_req = 1'b1; pops++;
            end else inst_req = 1'b0;
            cyc();
        end
        inst_req = 1'b0;
        n_cmp++; if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL cad_empty: got %b want 1", inst_empty); end
        // Requests into an empty queue must not disturb the pointers.
        inst_req = 1'b1; cyc(); cyc(); cyc(); inst_req = 1'b0;
        n_cmp++; if (inst_empty !== 1'b1 || instruct !== 220'h0) begin n_fail++; $display("FAIL cad_idle_req: got empty %b inst %h want 1 0", inst_empty, instruct); end
        go(16'h0300, 16'd1);
        for (int c = 1; c < 6; c++) cyc();
        n_cmp++; if (instruct !== exp_inst(16'h0300) || inst_empty !== 1'b0) begin n_fail++; $display("FAIL cad_after: got %h want %h", instruct, exp_inst(16'h0300)); end
        pop_once();
    endtask

    task automatic test_push_pop();
        go(16'h0400, 16'd2);
        for (int c = 1; c < 9; c++) cyc();
        n_cmp++; if (instruct !== exp_inst(16'h0400) || inst_empty !== 1'b0) begin n_fail++; $display("FAIL pp_head: got %h want %h", instruct, exp_inst(16'h0400)); end
        pop_once();
        n_cmp++; if (instruct !== exp_inst(16'h0404) || inst_empty !== 1'b0) begin n_fail++; $display("FAIL pp_new: got %h want %h", instruct, exp_inst(16'h0404)); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL pp_done: got %b want 1", done); end
        pop_once();
        n_cmp++; if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL pp_count: got empty %b want 1", inst_empty); end
    endtask

    task automatic test_reset_mid();
        go(16'h0500, 16'd4);
        cyc(); cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        n_cmp++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || inst_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid: got busy %b rd_en %b empty %b want 0 0 1", busy, mem_rd_en, inst_empty); end
        for (int c = 0; c < 8; c++) cyc();
        n_cmp++; if (inst_empty !== 1'b1 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: got empty %b rd_en %b want 1 0", inst_empty, mem_rd_en); end
        go(16'h0020, 16'd1);
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (mem_rd_addr !== 16'(16'h0020 + c) || mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_refetch_addr c%0d: got %h/%b want %h/1", c + 1, mem_rd_addr, mem_rd_en, 16'(16'h0020 + c)); end
            cyc();
        end
        cyc();
        n_cmp++; if (instruct !== exp_inst(16'h0020) || inst_empty !== 1'b0) begin n_fail++; $display("FAIL rst_refetch_inst: got %h want %h", instruct, exp_inst(16'h0020)); end
        pop_once();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_wrap();
        test_backpressure();
        test_cadence();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
